// File: rtl/alu_muldiv.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// One shift-add (multiply) or restoring-subtract (divide) step per clock behind start/busy/done.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] md_op_x,
    input  logic [WIDTH-1:0] md_op_y,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_div_zero,
    output logic [WIDTH-1:0] md_hi,
    output logic [WIDTH-1:0] md_lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               dz;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opb;

    logic               op_signed;
    logic               x_neg;
    logic               y_neg;
    logic [WIDTH-1:0]   x_mag;
    logic [WIDTH-1:0]   y_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        op_signed = (md_op == 3'd0) || (md_op == 3'd2);
        x_neg     = op_signed & md_op_x[WIDTH-1];
        y_neg     = op_signed & md_op_y[WIDTH-1];
        x_mag     = x_neg ? -md_op_x : md_op_x;
        y_mag     = y_neg ? -md_op_y : md_op_y;
        // acc_lo holds the multiplier (multiply) or the unconsumed dividend bits (divide)
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        rem_sh    = {acc_hi, acc_lo[WIDTH-1]};
        rem_diff  = rem_sh - {1'b0, opb};
        prod_fix  = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            dz          <= 1'b0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opb         <= '0;
            md_busy     <= 1'b0;
            md_done     <= 1'b0;
            md_div_zero <= 1'b0;
            md_hi       <= '0;
            md_lo       <= '0;
        end else begin
            md_done     <= 1'b0;
            md_div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (md_start) begin
                        case (md_op)
                            3'd4: md_hi <= md_op_x;
                            3'd5: md_lo <= md_op_x;
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                is_div  <= md_op[1];
                                neg_lo  <= x_neg ^ y_neg;
                                neg_hi  <= x_neg;
                                dz      <= md_op[1] && (md_op_y == '0);
                                acc_hi  <= '0;
                                acc_lo  <= x_mag;
                                opb     <= y_mag;
                                cnt     <= '0;
                                md_busy <= 1'b1;
                                state   <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        // Non-negative difference means the divisor fits: keep it and shift in a 1
                        if (!rem_diff[WIDTH]) begin
                            acc_hi <= rem_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= rem_sh[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        md_lo <= dz ? '1 : (neg_lo ? -acc_lo : acc_lo);
                        md_hi <= neg_hi ? -acc_hi : acc_hi;
                    end else begin
                        md_hi <= prod_fix[2*WIDTH-1:WIDTH];
                        md_lo <= prod_fix[WIDTH-1:0];
                    end
                    md_done     <= 1'b1;
                    md_div_zero <= dz;
                    md_busy     <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed 32-bit vectors with hand-computed results,
// plus an 8-bit instance checked against an arithmetic reference model.
module tb_alu_muldiv;
    logic        clk = 1'b0;
    logic        rst;

    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_op_x, md_op_y;
    logic        md_busy, md_done, md_div_zero;
    logic [31:0] md_hi, md_lo;

    logic        s_start;
    logic [2:0]  s_op;
    logic [7:0]  s_x, s_y;
    logic        s_busy, s_done, s_dz;
    logic [7:0]  s_hi, s_lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [64:0] q32[$];
    logic [16:0] q8[$];

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
        .md_op_x(md_op_x), .md_op_y(md_op_y), .md_busy(md_busy), .md_done(md_done),
        .md_div_zero(md_div_zero), .md_hi(md_hi), .md_lo(md_lo)
    );

    alu_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .md_start(s_start), .md_op(s_op),
        .md_op_x(s_x), .md_op_y(s_y), .md_busy(s_busy), .md_done(s_done),
        .md_div_zero(s_dz), .md_hi(s_hi), .md_lo(s_lo)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && md_done) begin
            if (q32.size() == 0) chk("done32_unexpected", 72'd1, 72'd0);
            else chk("result32 {dz,hi,lo}", {md_div_zero, md_hi, md_lo}, q32.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && s_done) begin
            if (q8.size() == 0) chk("done8_unexpected", 72'd1, 72'd0);
            else chk("result8 {dz,hi,lo}", {s_dz, s_hi, s_lo}, q8.pop_front());
        end
    end

    function automatic logic [16:0] ref8(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        int a, b, p, q, r;
        if (op == 3'd0 || op == 3'd2) begin
            a = int'($signed(x));
            b = int'($signed(y));
        end else begin
            a = int'(x);
            b = int'(y);
        end
        if (op < 3'd2) begin
            p = a * b;
            return {1'b0, p[15:0]};
        end
        if (b == 0) return {1'b1, x, 8'hFF};
        q = a / b;
        r = a % b;
        return {1'b0, r[7:0], q[7:0]};
    endfunction

    // Called at a negedge; request is accepted on the following posedge
    task automatic issue32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        md_start = 1'b1;
        md_op    = op;
        md_op_x  = x;
        md_op_y  = y;
        @(negedge clk);
        md_start = 1'b0;
        md_op_x  = $urandom();
        md_op_y  = $urandom();
    endtask

    task automatic wait32(input string name, input int exp_lat);
        int k = 0;
        int b = 0;
        while (!md_done && k < 100) begin
            if (md_busy) b++;
            @(negedge clk);
            k++;
        end
        chk({name, "_latency"}, 72'(k), 72'(exp_lat));
        chk({name, "_busy_cycles"}, 72'(b), 72'(exp_lat));
    endtask

    task automatic run32(input string name, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic dz, input logic [31:0] hi,
                         input logic [31:0] lo);
        q32.push_back({dz, hi, lo});
        issue32(op, x, y);
        wait32(name, 33);
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        int k = 0;
        q8.push_back(ref8(op, x, y));
        s_start = 1'b1;
        s_op    = op;
        s_x     = x;
        s_y     = y;
        @(negedge clk);
        s_start = 1'b0;
        s_x     = 8'($urandom());
        s_y     = 8'($urandom());
        while (!s_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("latency8", 72'(k), 72'd9);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] v_op[8] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3};
        logic [7:0] v_x[8]  = '{8'hFD, 8'hFF, 8'hFF, 8'hF9, 8'h64, 8'h80, 8'hF9, 8'hC8};
        logic [7:0] v_y[8]  = '{8'h07, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h07};

        rst = 1'b1;
        md_start = 1'b0; md_op = 3'd0; md_op_x = '0; md_op_y = '0;
        s_start = 1'b0; s_op = 3'd0; s_x = '0; s_y = '0;
        repeat (3) @(negedge clk);
        chk("reset_state32", {md_busy, md_done, md_div_zero, md_hi, md_lo}, '0);
        chk("reset_state8", {s_busy, s_done, s_dz, s_hi, s_lo}, '0);
        rst = 1'b0;
        @(negedge clk);

        run32("mult_neg3x7", 3'd0, 32'hFFFFFFFD, 32'h00000007, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        // Back-to-back: next request issued in the cycle md_done is seen
        run32("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        run32("mult_m1xm1", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001);
        run32("div_m7d2", 3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run32("div_7dm2", 3'd2, 32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD);
        run32("divu_by0", 3'd3, 32'h00000064, 32'h00000000, 1'b1, 32'h00000064, 32'hFFFFFFFF);
        @(negedge clk);
        chk("div_zero_one_cycle", {md_div_zero, md_done}, 72'd0);
        run32("div_minneg", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000);

        // MTHI during a MULT must be ignored
        q32.push_back({1'b0, 32'h00000000, 32'h0000001E});
        issue32(3'd0, 32'd5, 32'd6);
        repeat (3) @(negedge clk);
        md_start = 1'b1; md_op = 3'd4; md_op_x = 32'h12345678;
        @(negedge clk);
        md_start = 1'b0;
        wait32("mult_with_mthi", 29);

        issue32(3'd6, 32'hCAFEF00D, 32'd1);
        chk("noop_op6", {md_busy, md_hi, md_lo}, {1'b0, 32'h00000000, 32'h0000001E});
        issue32(3'd4, 32'h12345678, 32'd0);
        chk("mthi_idle", {md_busy, md_hi}, {1'b0, 32'h12345678});

        // Reset mid-divide: no done, HI/LO cleared
        issue32(3'd3, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", {md_busy, md_hi, md_lo}, '0);
        repeat (40) @(negedge clk);
        chk("abort_no_restart", {md_busy, md_done}, '0);

        issue32(3'd5, 32'hDEADBEEF, 32'd0);
        chk("mtlo", {md_busy, md_lo}, {1'b0, 32'hDEADBEEF});
        @(negedge clk);
        chk("mtlo_no_busy", {md_busy, md_done}, '0);

        for (int i = 0; i < 8; i++) run8(v_op[i], v_x[i], v_y[i]);

        repeat (3) @(negedge clk);
        chk("queues_drained", 72'(q32.size() + q8.size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
